// File: rtl/laser_point_cover.sv
// laser_point_cover
// Captures the 40-point target image streamed right after reset, then answers
// coverage queries: how many stored points lie within the radius of a candidate
// centre C and not within the radius of an optional exclusion centre E.
// One point is scanned per clock, so each query occupies the block for
// N_POINTS scan cycles plus one response cycle.

module laser_point_cover #(
    parameter int N_POINTS  = 40,
    parameter int COORD_W   = 4,
    parameter int RADIUS_SQ = 16
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic [COORD_W-1:0]                X,
    input  logic [COORD_W-1:0]                Y,
    output logic                              load_done,
    input  logic                              q_valid,
    output logic                              q_ready,
    input  logic [COORD_W-1:0]                q_cx,
    input  logic [COORD_W-1:0]                q_cy,
    input  logic [COORD_W-1:0]                q_ex,
    input  logic [COORD_W-1:0]                q_ey,
    input  logic                              q_ex_en,
    output logic                              r_valid,
    output logic [$clog2(N_POINTS+1)-1:0]     r_count
);

    localparam int IDX_W = $clog2(N_POINTS);
    localparam int CNT_W = $clog2(N_POINTS + 1);
    localparam int SQ_W  = 2 * COORD_W;       // one squared difference
    localparam int SUM_W = 2 * COORD_W + 1;   // dx^2 + dy^2

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_POINTS - 1);
    localparam logic [SUM_W-1:0] LIMIT_SQ  = SUM_W'(RADIUS_SQ);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        IDLE = 2'd1,
        SCAN = 2'd2,
        RESP = 2'd3
    } state_t;

    // Squared euclidean distance between a stored point and a centre.
    // Differences are taken one bit wider and signed, so 0 and 15 are
    // 15 apart; there is no wrap-around on the grid.
    function automatic logic [SUM_W-1:0] dist_sq(
        input logic [COORD_W-1:0] px,
        input logic [COORD_W-1:0] py,
        input logic [COORD_W-1:0] cx,
        input logic [COORD_W-1:0] cy
    );
        logic signed [COORD_W:0] dx;
        logic signed [COORD_W:0] dy;
        logic        [COORD_W:0] ax;
        logic        [COORD_W:0] ay;
        logic        [SQ_W-1:0]  sx;
        logic        [SQ_W-1:0]  sy;
        dx = $signed({1'b0, px}) - $signed({1'b0, cx});
        dy = $signed({1'b0, py}) - $signed({1'b0, cy});
        ax = (dx < 0) ? -dx : dx;
        ay = (dy < 0) ? -dy : dy;
        sx = SQ_W'(ax) * SQ_W'(ax);
        sy = SQ_W'(ay) * SQ_W'(ay);
        return SUM_W'(sx) + SUM_W'(sy);
    endfunction

    // ------------------------------------------------------------------
    // State and storage
    // ------------------------------------------------------------------
    state_t                     r_state;
    state_t                     w_next_state;

    logic [2*COORD_W-1:0]       r_buf [N_POINTS];
    logic [IDX_W-1:0]           r_idx;
    logic [CNT_W-1:0]           r_acc;

    logic [COORD_W-1:0]         r_cx;
    logic [COORD_W-1:0]         r_cy;
    logic [COORD_W-1:0]         r_ex;
    logic [COORD_W-1:0]         r_ey;
    logic                       r_ex_en;

    // ------------------------------------------------------------------
    // Scan datapath
    // ------------------------------------------------------------------
    logic [2*COORD_W-1:0]       w_point;
    logic [COORD_W-1:0]         w_px;
    logic [COORD_W-1:0]         w_py;
    logic                       w_in_c;
    logic                       w_in_e;
    logic                       w_covered;
    logic                       w_idx_last;
    logic                       w_accept;
    logic [CNT_W-1:0]           w_acc_next;

    assign w_point    = r_buf[r_idx];
    assign w_px       = w_point[2*COORD_W-1:COORD_W];
    assign w_py       = w_point[COORD_W-1:0];
    assign w_in_c     = dist_sq(w_px, w_py, r_cx, r_cy) <= LIMIT_SQ;
    assign w_in_e     = dist_sq(w_px, w_py, r_ex, r_ey) <= LIMIT_SQ;
    assign w_covered  = w_in_c && !(r_ex_en && w_in_e);
    assign w_idx_last = (r_idx == LAST_IDX);
    assign w_accept   = q_valid && (r_state == IDLE);
    assign w_acc_next = r_acc + CNT_W'(w_covered);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register; reset always restarts the load.
    always_ff @(posedge CLK) begin
        // NOTE: state elements use non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (RST) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default first, so no path through the case leaves the
        // output unassigned and infers a latch.
        w_next_state = r_state;
        case (r_state)
            LOAD:    if (w_idx_last) w_next_state = IDLE;
            IDLE:    if (q_valid)    w_next_state = SCAN;
            SCAN:    if (w_idx_last) w_next_state = RESP;
            RESP:                    w_next_state = IDLE;
            default:                 w_next_state = LOAD;
        endcase
    end

    // Handshake outputs are pure decodes of the state register, so q_ready
    // never depends combinationally on q_valid.
    always_comb begin
        load_done = (r_state != LOAD);
        q_ready   = (r_state == IDLE);
        r_valid   = (r_state == RESP);
    end

    // ------------------------------------------------------------------
    // Point buffer
    // ------------------------------------------------------------------

    // Capture one streamed point per cycle while loading.
    always_ff @(posedge CLK) begin
        // NOTE: the buffer has no reset; every entry is rewritten during
        // LOAD before it is read, and leaving it out keeps it mappable to RAM.
        if (!RST && (r_state == LOAD)) begin
            r_buf[r_idx] <= {X, Y};
        end
    end

    // ------------------------------------------------------------------
    // Index, accumulator, query latch and result
    // ------------------------------------------------------------------

    // Walk the buffer during load/scan, latch queries, accumulate coverage.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_idx   <= '0;
            r_acc   <= '0;
            r_count <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
            r_ex    <= '0;
            r_ey    <= '0;
            r_ex_en <= 1'b0;
        end else begin
            case (r_state)
                LOAD: begin
                    r_idx <= w_idx_last ? '0 : r_idx + IDX_W'(1);
                end
                IDLE: begin
                    if (w_accept) begin
                        r_cx    <= q_cx;
                        r_cy    <= q_cy;
                        r_ex    <= q_ex;
                        r_ey    <= q_ey;
                        r_ex_en <= q_ex_en;
                        r_acc   <= '0;
                        r_idx   <= '0;
                    end
                end
                SCAN: begin
                    r_acc <= w_acc_next;
                    r_idx <= w_idx_last ? '0 : r_idx + IDX_W'(1);
                    // The last point's contribution is folded in directly.
                    if (w_idx_last) begin
                        r_count <= w_acc_next;
                    end
                end
                default: begin
                    // RESP: r_count holds until the next query completes.
                end
            endcase
        end
    end

endmodule
